// File: rtl/gcd_pack.sv
// Shared types and defaults for the subtractive GCD engine.
package gcd_pack;

    localparam int GCD_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// One compare/subtract step of the GCD datapath: equality, ordering and
// the non-negative difference of the two operands.
module gcd_step
    import gcd_pack::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] diff
);

    always_comb begin
        eq     = (a == b);
        a_gt_b = (a > b);
        diff   = a_gt_b ? (a - b) : (b - a);
    end

endmodule

// File: rtl/gcd_core.sv
// Iterative subtractive GCD engine: IDLE/CALC/DONE FSM with a/b/result regs.
// Define GCD_ITER_CNT_EN to add the iter_cnt port and its saturating counter.
module gcd_core
    import gcd_pack::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    gcd_state_t       state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt, result_nxt;
    logic             eq, a_gt_b;
    logic [WIDTH-1:0] diff;

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_q),
        .b      (b_q),
        .eq     (eq),
        .a_gt_b (a_gt_b),
        .diff   (diff)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt  = state;
        a_nxt      = a_q;
        b_nxt      = b_q;
        result_nxt = result;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt = a_in;
                    b_nxt = b_in;
                    if (a_in == '0 || b_in == '0) begin
                        result_nxt = a_in | b_in;
                        state_nxt  = DONE;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (eq) begin
                    result_nxt = a_q;
                    state_nxt  = DONE;
                end else if (a_gt_b) begin
                    a_nxt = diff;
                end else begin
                    b_nxt = diff;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset is itself gated by clk_en: a disabled clock freezes everything.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            if (rst) begin
                state  <= IDLE;
                a_q    <= '0;
                b_q    <= '0;
                result <= '0;
            end else begin
                state  <= state_nxt;
                a_q    <= a_nxt;
                b_q    <= b_nxt;
                result <= result_nxt;
            end
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

`ifdef GCD_ITER_CNT_EN
    // Counts subtract steps only; the final a==b cycle is not a step.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                iter_cnt <= '0;
            end else if (state == IDLE && start) begin
                iter_cnt <= '0;
            end else if (state == CALC && !eq && iter_cnt != '1) begin
                iter_cnt <= iter_cnt + WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed cases plus randomized operands
// checked against a Euclid-based reference model.
module tb_gcd_core;
    localparam int W      = 32;
    localparam int BUDGET = 5000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clk_en = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done;
    logic [W-1:0] result;
`ifdef GCD_ITER_CNT_EN
    logic [W-1:0] iter_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gcd_core #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: gcd from Euclid's remainder form; the subtractive step count
    // is the sum of Euclid quotients minus the final equal-operands cycle.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] g, output int steps);
        longint unsigned x, y, r, q_sum;
        if (a == '0 || b == '0) begin
            g     = a | b;
            steps = 0;
            return;
        end
        x     = (a > b) ? 64'(a) : 64'(b);
        y     = (a > b) ? 64'(b) : 64'(a);
        q_sum = 0;
        while (y != 0) begin
            q_sum += x / y;
            r = x % y;
            x = y;
            y = r;
        end
        g     = W'(x);
        steps = int'(q_sum - 1);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit toggle, input int stray_at, input string tag);
        logic [W-1:0] exp_res;
        int           exp_steps, exp_lat, lat, cyc, width, extra;
        bit           busy_seen, en_prev;
        model(a, b, exp_res, exp_steps);
        exp_lat = (a == '0 || b == '0) ? 0 : exp_steps + 1;

        clk_en = 1'b1;
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        tick();
        start = 1'b0;

        lat = 0;
        cyc = 0;
        busy_seen = 1'b0;
        while (!done && cyc < BUDGET) begin
            if (busy) busy_seen = 1'b1;
            if (cyc == stray_at) begin
                start = 1'b1;
                a_in  = a + 7;
                b_in  = b + 3;
            end else begin
                start = 1'b0;
            end
            if (toggle) clk_en = ~clk_en;
            en_prev = clk_en;
            tick();
            cyc++;
            if (en_prev) lat++;
        end
        start = 1'b0;

        check({tag, " done_seen"}, 64'(done), 1);
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy_seen"}, 64'(busy_seen), 64'(exp_lat != 0));
`ifdef GCD_ITER_CNT_EN
        check({tag, " iter_cnt"}, 64'(iter_cnt), 64'(exp_steps));
`endif

        width = 0;
        while (done && width < 10) begin
            if (toggle) clk_en = ~clk_en;
            tick();
            width++;
        end
        check({tag, " done_width"}, 64'(width), toggle ? 2 : 1);

        clk_en = 1'b1;
        extra  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) extra++;
        end
        check({tag, " no_extra_done"}, 64'(extra), 0);
        check({tag, " result_held"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           pulses;

        // Reset state
        rst    = 1'b1;
        clk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", 64'(busy), 0);
        check("reset done", 64'(done), 0);
        check("reset result", 64'(result), 0);
`ifdef GCD_ITER_CNT_EN
        check("reset iter_cnt", 64'(iter_cnt), 0);
`endif

        run_op(12, 8, 1'b0, -1, "gcd_12_8");
        run_op(0, 35, 1'b0, -1, "gcd_0_35");
        run_op(0, 0, 1'b0, -1, "gcd_0_0");
        run_op(77, 77, 1'b0, -1, "gcd_x_x");
        run_op(1071, 462, 1'b0, 5, "gcd_stray_start");
        run_op(48, 18, 1'b1, -1, "gcd_clken_toggle");

        // rst is ignored while clk_en is low
        clk_en = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        clk_en = 1'b1;
        check("gated rst result", 64'(result), 6);

        // Abort mid-CALC
        start = 1'b1;
        a_in  = 1000;
        b_in  = 3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort busy_before", 64'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 64'(busy), 0);
        check("abort done", 64'(done), 0);
        check("abort result", 64'(result), 0);
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("abort stays idle", 64'(pulses), 0);
        run_op(9, 6, 1'b0, -1, "gcd_after_abort");

        // Randomized operands, some zero, random clock-enable toggling
        for (int n = 0; n < 24; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 300));
            run_op(ra, rb, 1'($urandom_range(0, 1)), -1, $sformatf("rand%0d_%0d_%0d", n, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
